// File: rtl/find_emax_lanes.sv
// rtl/find_emax_lanes.sv - multi-lane block max-exponent finder with valid/ready result
// Folds LANES exponents per beat into a running block max; one registered result per block.
module find_emax_lanes #(
   parameter int FP_W  = 32,
   parameter int EXP_W = 8,
   parameter int LANES = 1,
   parameter int BLOCK = 4,
   localparam int BEATS = BLOCK / LANES,
   localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  s_fp,
   input  logic [LANES*FP_W-1:0] s_data,
   input  logic                  s_last,
   output logic                  c_fp,
   output logic [EXP_W-1:0]      m_emax,
   output logic                  m_zero,
   output logic                  m_special,
   output logic [CNT_W:0]        m_beats,
   output logic                  emax_v,
   input  logic                  c_ex
);

   localparam int EXP_LSB = FP_W - 1 - EXP_W;

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [EXP_W-1:0] run_max_q, run_max_d;
   logic             run_spc_q, run_spc_d;
   logic [CNT_W:0]   seen_q, seen_d;
   logic [EXP_W-1:0] emax_q, emax_d;
   logic             zero_q, zero_d;
   logic             spc_q, spc_d;
   logic [CNT_W:0]   beats_q, beats_d;
   logic             valid_q, valid_d;

   logic [EXP_W-1:0] lane_exp;
   logic [EXP_W-1:0] beat_max;
   logic             beat_spc;
   logic [EXP_W-1:0] merged_max;
   logic             merged_spc;
   logic             accept;
   logic             last_beat;

   // Sign and mantissa bits never participate.
   logic data_unused;
   assign data_unused = ^s_data;

   always_comb begin
      lane_exp = '0;
      beat_max = '0;
      beat_spc = 1'b0;
      for (int i = 0; i < LANES; i++) begin
         lane_exp = s_data[i*FP_W + EXP_LSB +: EXP_W];
         if (lane_exp > beat_max) beat_max = lane_exp;
         if (&lane_exp) beat_spc = 1'b1;
      end
   end

   assign c_fp       = !valid_q || c_ex;
   assign accept     = s_fp && c_fp;
   assign last_beat  = (cnt_q == '0) || s_last;
   assign merged_max = (beat_max > run_max_q) ? beat_max : run_max_q;
   assign merged_spc = run_spc_q | beat_spc;

   always_comb begin
      cnt_d     = cnt_q;
      run_max_d = run_max_q;
      run_spc_d = run_spc_q;
      seen_d    = seen_q;
      emax_d    = emax_q;
      zero_d    = zero_q;
      spc_d     = spc_q;
      beats_d   = beats_q;
      valid_d   = valid_q && !c_ex;
      if (accept) begin
         if (last_beat) begin
            // A drain in the same cycle is overridden by the freshly completed block.
            emax_d    = merged_max;
            zero_d    = (merged_max == '0);
            spc_d     = merged_spc;
            beats_d   = seen_q + (CNT_W+1)'(1);
            valid_d   = 1'b1;
            cnt_d     = CNT_W'(BEATS - 1);
            run_max_d = '0;
            run_spc_d = 1'b0;
            seen_d    = '0;
         end else begin
            cnt_d     = cnt_q - CNT_W'(1);
            run_max_d = merged_max;
            run_spc_d = merged_spc;
            seen_d    = seen_q + (CNT_W+1)'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q     <= CNT_W'(BEATS - 1);
         run_max_q <= '0;
         run_spc_q <= 1'b0;
         seen_q    <= '0;
         emax_q    <= '0;
         zero_q    <= 1'b0;
         spc_q     <= 1'b0;
         beats_q   <= '0;
         valid_q   <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         run_max_q <= run_max_d;
         run_spc_q <= run_spc_d;
         seen_q    <= seen_d;
         emax_q    <= emax_d;
         zero_q    <= zero_d;
         spc_q     <= spc_d;
         beats_q   <= beats_d;
         valid_q   <= valid_d;
      end
   end

   assign m_emax    = emax_q;
   assign m_zero    = zero_q;
   assign m_special = spc_q;
   assign m_beats   = beats_q;
   assign emax_v    = valid_q;

endmodule

// File: doc/find_emax_lanes.md
Name: find_emax_lanes

Overview:
- Parametrised successor to the single-lane ZFP max-exponent finder in the block-floating-point compressor front end.
- Accepts LANES IEEE-format values per beat over a block of BLOCK values and emits the block's maximum biased exponent through a valid/ready handshake.
- Adds beyond the single-lane version: multi-lane beats, early block termination (s_last), all-zero and special (Inf/NaN) block flags, and a per-block value count.
- Sits between the input FP stream and the block-exponent alignment stage.

Parameters:
- FP_W, 32, total float width in bits.
- EXP_W, 8, exponent field width. Exponent is bits [FP_W-2 : FP_W-1-EXP_W]; sign is ignored.
- LANES, 1, values per input beat.
- BLOCK, 4, values per block. BLOCK % LANES == 0 is required; BEATS = BLOCK/LANES.
- CNT_W, max(1,clog2(BEATS)), beat counter width (derived; not for override).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- s_fp  in  1  input beat valid.
- s_data  in  LANES*FP_W  lane i occupies bits [i*FP_W +: FP_W].
- s_last  in  1  forces this beat to end the block early.
- c_fp  out  1  input ready.
- m_emax  out  EXP_W  block max biased exponent.
- m_zero  out  1  every exponent in the block was 0.
- m_special  out  1  some exponent in the block was all-ones.
- m_beats  out  CNT_W+1  number of beats accepted in the block (1..BEATS).
- emax_v  out  1  output valid.
- c_ex  in  1  downstream ready.

Behaviour:
- Reset (synchronous, dominates all other inputs):
  - Outputs: emax_v=0, m_emax=0, m_zero=0, m_special=0, m_beats=0.
  - Internal state: beat counter = BEATS-1, running max = 0, running special = 0, beats-seen = 0.
  - Reset mid-block discards the partial block; no output is produced for it.
- Ready: c_fp = !emax_v || c_ex (combinational). Accept = s_fp && c_fp.
- Beat max: combinational max over LANES exponents, unsigned compare. Beat special = OR of (exponent == all-ones).
- Last beat: last = (counter == 0) || s_last, sampled on the accepting beat.
- On accept, not last:
  - counter decrements.
  - running max = max(running, beat max); running special |= beat special; beats-seen increments.
- On accept, last:
  - Outputs take the final values: m_emax = max(running, beat max); m_special = running special | beat special; m_zero = (final emax == 0); m_beats = beats-seen + 1.
  - emax_v = 1.
  - counter reloads to BEATS-1; running max, running special and beats-seen clear.
- Latency: emax_v rises on the clock edge after the last beat is accepted, i.e. 1 cycle.
- Output hold: emax_v and all m_* stay stable while emax_v && !c_ex. emax_v clears on c_ex unless a new last beat is accepted in the same cycle, in which case the new result is loaded and emax_v stays 1.
- Simultaneous drain and first beat of the next block: the first beat goes into the cleared running state and is never merged with the old block.
- Back-to-back single-beat blocks (BEATS=1 or s_last every beat) sustain one result per cycle when c_ex=1.
- s_last on a beat where counter==0 is redundant; behaviour is identical to counter==0.
- Denormals (exponent 0) compare as 0. Inf/NaN compare as all-ones and also set m_special.
- When s_fp=0, s_data and s_last are ignored.

Test Plan:
- LANES=1, BLOCK=4, c_ex=1. Feed 0x3F800000, 0x40000000, 0xC1000000, 0x40800000 -> one cycle after the 4th beat: emax_v=1, m_emax=130, m_zero=0, m_special=0, m_beats=4.
- LANES=2, BLOCK=4. Beats {0x3F800000,0x40800000} then {0x00000000,0x40000000} -> m_emax=129, m_beats=2. Then all-zero lanes for two beats -> m_emax=0, m_zero=1.
- Backpressure: hold c_ex=0 after a result -> c_fp=0, next block stalls, outputs stable 5 cycles. Raise c_ex with the next first beat valid -> beat accepted same cycle, new block result correct and unpolluted by the old one.
- Early end: LANES=1, BLOCK=4, s_last on beat 2 with 0x40000000, 0x7F800000 -> m_emax=255, m_special=1, m_beats=2. The following block starts a full 4-beat count.
- Reset mid-block: two beats (exp 140) accepted, reset for 1 cycle, then 4 beats of exp 127 -> a single result m_emax=127, m_beats=4; no output for the aborted block.
- Throughput: LANES=4, BLOCK=4, c_ex=1, s_fp held high 6 cycles -> emax_v high 6 consecutive cycles, each m_emax equal to that beat's lane max.
